// File: rtl/frame_pixel_sequencer.sv
// Frame sequencer: paces one image of upstream pixels into a single-strobe window filter,
// then appends padding rows so the filter's line buffers drain. Optional: SEQ_STALL_CNT_EN.
module frame_pixel_sequencer #(
  parameter int          IMAGE_WIDTH  = 320,
  parameter int          IMAGE_HEIGHT = 240,
  parameter int          PIX_GAP      = 2,
  parameter int          FLUSH_ROWS   = 1,
  parameter logic [7:0]  PAD_VALUE    = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  output logic [15:0] pix_row,
  output logic [15:0] pix_col,
  output logic        pix_is_pad,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] stall_cnt
);

  localparam int GW = $clog2(PIX_GAP + 2);

  localparam logic [15:0]   LAST_COL     = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0]   LAST_ROW     = 16'(IMAGE_HEIGHT - 1);
  localparam logic [15:0]   LAST_PAD_ROW = 16'(IMAGE_HEIGHT + FLUSH_ROWS - 1);
  localparam logic [GW-1:0] GAP_RELOAD   = GW'((PIX_GAP > 0) ? PIX_GAP - 1 : 0);
  localparam logic [GW-1:0] DRAIN_RELOAD = GW'(PIX_GAP);
  localparam bit            HAS_FLUSH    = (FLUSH_ROWS > 0);
  localparam bit            HAS_GAP      = (PIX_GAP > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_GAP,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          state, state_d;
  state_t          gap_next, gap_next_d;
  logic [GW-1:0]   gap_left, gap_left_d;
  logic [15:0]     row_cnt, col_cnt;

  logic handshake, pad_issue, issue;
  logic at_row_end, last_real, last_pad, final_issue;
  logic start_accept;
  state_t after_issue;

  assign handshake    = (state == S_FEED)  && in_valid && !abort;
  assign pad_issue    = (state == S_FLUSH) && !abort;
  assign issue        = handshake || pad_issue;
  assign start_accept = (state == S_IDLE)  && start && !abort;

  assign at_row_end = (col_cnt == LAST_COL);
  assign last_real  = at_row_end && (row_cnt == LAST_ROW);
  assign last_pad   = at_row_end && (row_cnt == LAST_PAD_ROW);

  // The very last strobe of a frame keeps one extra gap cycle so DONE lands
  // exactly PIX_GAP+1 cycles after it, matching the spacing of ordinary strobes.
  assign final_issue = (handshake && last_real && !HAS_FLUSH) || (pad_issue && last_pad);

  always_comb begin
    after_issue = S_FLUSH;
    if (handshake && !last_real) after_issue = S_FEED;
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d    = state;
    gap_next_d = gap_next;
    gap_left_d = gap_left;

    case (state)
      S_IDLE: begin
        if (start) state_d = S_FEED;
      end
      S_FEED, S_FLUSH: begin
        if (issue) begin
          if (final_issue) begin
            state_d    = S_GAP;
            gap_next_d = S_DONE;
            gap_left_d = DRAIN_RELOAD;
          end else if (HAS_GAP) begin
            state_d    = S_GAP;
            gap_next_d = after_issue;
            gap_left_d = GAP_RELOAD;
          end else begin
            state_d    = after_issue;
          end
        end
      end
      S_GAP: begin
        if (gap_left == '0) state_d    = gap_next;
        else                gap_left_d = gap_left - 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gap_next <= S_IDLE;
      gap_left <= '0;
    end else begin
      state    <= state_d;
      gap_next <= gap_next_d;
      gap_left <= gap_left_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (start_accept) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (issue) begin
      if (at_row_end) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + 16'd1;
      end else begin
        col_cnt <= col_cnt + 16'd1;
      end
    end
  end

  // Strobe tags and data hold between strobes; only pix_valid returns to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_row    <= '0;
      pix_col    <= '0;
      pix_is_pad <= 1'b0;
    end else begin
      pix_valid <= issue;
      if (issue) begin
        pix_data   <= handshake ? in_data : PAD_VALUE;
        pix_row    <= row_cnt;
        pix_col    <= col_cnt;
        pix_is_pad <= pad_issue;
      end
    end
  end

  // in_ready drops during abort so upstream never sees a pixel as consumed that was dropped.
  assign in_ready   = (state == S_FEED) && !abort;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

`ifdef SEQ_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_accept) begin
      stall_q <= '0;
    end else if ((state == S_FEED) && !in_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  // Row counter is 16 bits and must cover the padding rows as well.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (IMAGE_HEIGHT + FLUSH_ROWS < 65536)
        else $error("IMAGE_HEIGHT+FLUSH_ROWS exceeds the 16-bit row counter");
    end
  end

endmodule

// File: tb/tb_frame_pixel_sequencer.sv
// Directed bench for frame_pixel_sequencer: 4x3 image with gap/flush, plus a
// back-to-back (PIX_GAP=0, FLUSH_ROWS=0) instance.
module tb_frame_pixel_sequencer;

`ifdef SEQ_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, pix_valid, pix_is_pad, busy, frame_done;
  logic [7:0]  pix_data;
  logic [15:0] pix_row, pix_col;
  logic [31:0] stall_cnt;

  frame_pixel_sequencer #(
    .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .PIX_GAP(2), .FLUSH_ROWS(1), .PAD_VALUE(8'h00)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .pix_is_pad(pix_is_pad), .busy(busy), .frame_done(frame_done), .stall_cnt(stall_cnt)
  );

  logic        f_start = 1'b0, f_abort = 1'b0, f_in_valid = 1'b0;
  logic [7:0]  f_in_data = '0;
  logic        f_in_ready, f_pix_valid, f_pix_is_pad, f_busy, f_frame_done;
  logic [7:0]  f_pix_data;
  logic [15:0] f_pix_row, f_pix_col;
  logic [31:0] f_stall_cnt;

  frame_pixel_sequencer #(
    .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .PIX_GAP(0), .FLUSH_ROWS(0), .PAD_VALUE(8'h00)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .start(f_start), .abort(f_abort),
    .in_valid(f_in_valid), .in_data(f_in_data), .in_ready(f_in_ready),
    .pix_valid(f_pix_valid), .pix_data(f_pix_data), .pix_row(f_pix_row), .pix_col(f_pix_col),
    .pix_is_pad(f_pix_is_pad), .busy(f_busy), .frame_done(f_frame_done), .stall_cnt(f_stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [7:0]  d;
    logic [15:0] r;
    logic [15:0] c;
    logic        p;
  } strobe_t;

  strobe_t     sq[$];
  int          fd_count;
  int          fd_cyc;
  logic        busy_after;
  logic [31:0] sc_at_done;

  function automatic logic [63:0] pack(int off, logic [7:0] d, logic [15:0] r,
                                       logic [15:0] c, logic p);
    return {7'b0, 16'(off), d, r, c, p};
  endfunction

  function automatic logic [44:0] main_outs();
    return {in_ready, pix_valid, pix_data, pix_row, pix_col, pix_is_pad, busy, frame_done};
  endfunction

  task automatic feed_pixels(input int stall_idx, input int abort_idx);
    int idx = 0, stall_left = 5, guard = 0;
    bit hs, aborted = 1'b0;
    while (idx < 12 && guard < 300 && !aborted) begin
      hs = 1'b0;
      if (idx == stall_idx && stall_left > 0) begin
        in_valid = 1'b0;
        if (in_ready) stall_left--;
      end else begin
        in_valid = 1'b1;
        in_data  = 8'(10 + idx);
        hs       = in_ready;
        if (hs && idx == abort_idx) begin
          abort = 1'b1;
          #1 check("abort_in_ready", in_ready, 1'b0);
          aborted = 1'b1;
        end
      end
      @(negedge clk);
      guard++;
      if (aborted) begin
        abort = 1'b0;
        check("abort_idle", {busy, pix_valid, frame_done}, 3'b000);
      end else if (hs) begin
        idx++;
      end
    end
    in_valid = 1'b0;
    if (!aborted) check("feed_all_accepted", idx, 12);
  endtask

  task automatic collect(input int budget);
    sq.delete();
    fd_count   = 0;
    fd_cyc     = -1;
    busy_after = 1'b1;
    sc_at_done = 32'hDEAD_BEEF;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pix_valid) sq.push_back('{cyc: cyc, d: pix_data, r: pix_row, c: pix_col, p: pix_is_pad});
      if (frame_done) begin
        fd_count++;
        fd_cyc     = cyc;
        sc_at_done = stall_cnt;
      end else if (fd_cyc >= 0) begin
        busy_after = busy;
        break;
      end
    end
  endtask

  task automatic poke_start_in_flush();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pix_valid && pix_is_pad) begin
        start = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_frame(input int stall_idx, input int abort_idx, input bit flush_start,
                           input int budget, output int base);
    @(negedge clk);
    start = 1'b1;
    base  = cyc + 2;
    @(negedge clk);
    start = 1'b0;
    fork
      feed_pixels(stall_idx, abort_idx);
      collect(budget);
      begin
        if (flush_start) poke_start_in_flush();
      end
    join
  endtask

  // Expected strobe k: 12 real pixels then 4 pads on row 3, period 3, optional 5-cycle stall.
  task automatic check_strobes(input string tag, input int base, input int stall_idx, input int n);
    int off;
    check({tag, "_n_strobes"}, sq.size(), n);
    for (int k = 0; k < n && k < sq.size(); k++) begin
      off = 3 * k + ((stall_idx >= 0 && k >= stall_idx) ? 5 : 0);
      if (k < 12)
        check($sformatf("%s_strobe%0d", tag, k),
              pack(sq[k].cyc - base, sq[k].d, sq[k].r, sq[k].c, sq[k].p),
              pack(off, 8'(10 + k), 16'(k / 4), 16'(k % 4), 1'b0));
      else
        check($sformatf("%s_pad%0d", tag, k - 12),
              pack(sq[k].cyc - base, sq[k].d, sq[k].r, sq[k].c, sq[k].p),
              pack(off, 8'h00, 16'd3, 16'(k - 12), 1'b1));
    end
  endtask

  task automatic check_frame_end(input string tag, input int base, input int extra,
                                 input logic [31:0] exp_stall);
    check({tag, "_fd_count"}, fd_count, 1);
    check({tag, "_fd_time"}, fd_cyc - base, 48 + extra);
    check({tag, "_busy_after"}, busy_after, 1'b0);
    check({tag, "_stall_cnt"}, sc_at_done, exp_stall);
  endtask

  initial begin
    int base, n;

    #12;
    check("reset_outs", main_outs(), '0);
    check("reset_stall", stall_cnt, '0);
    check("reset_fast", {f_in_ready, f_pix_valid, f_busy, f_frame_done}, 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", main_outs(), '0);

    run_frame(-1, -1, 1'b0, 200, base);
    check_strobes("nominal", base, -1, 16);
    check_frame_end("nominal", base, 0, 32'd0);

    run_frame(5, -1, 1'b0, 200, base);
    check_strobes("starve", base, 5, 16);
    check_frame_end("starve", base, 5, STALL_EN ? 32'd5 : 32'd0);

    run_frame(-1, 4, 1'b0, 30, base);
    check_strobes("abort", base, -1, 4);
    check("abort_no_done", fd_count, 0);

    run_frame(-1, -1, 1'b0, 200, base);
    check_strobes("restart", base, -1, 16);
    check_frame_end("restart", base, 0, 32'd0);

    run_frame(-1, -1, 1'b1, 200, base);
    check_strobes("flush_start", base, -1, 16);
    check_frame_end("flush_start", base, 0, 32'd0);

    // Back-to-back instance: one strobe per cycle, DONE right after the last one.
    @(negedge clk);
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      f_in_valid = 1'b1;
      f_in_data  = 8'(10 + i);
      check($sformatf("fast_ready%0d", i), f_in_ready, 1'b1);
      @(negedge clk);
      check($sformatf("fast_strobe%0d", i),
            {f_pix_valid, f_pix_data, f_pix_row, f_pix_col, f_pix_is_pad},
            {1'b1, 8'(10 + i), 16'(i / 4), 16'(i % 4), 1'b0});
    end
    f_in_valid = 1'b0;
    check("fast_ready_end", {f_in_ready, f_frame_done}, 2'b00);
    @(negedge clk);
    check("fast_done", {f_pix_valid, f_frame_done, f_busy}, 3'b011);
    @(negedge clk);
    check("fast_idle", {f_pix_valid, f_frame_done, f_busy}, 3'b000);

    // Async reset pulse in the middle of a GAP, shorter than a clock period.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge clk);
      if (pix_valid) n++;
    end
    check("rst_pre_strobes", n, 2);
    #1 rst_n = 1'b0;
    #1 check("rst_async_outs", main_outs(), '0);
    check("rst_async_stall", stall_cnt, '0);
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_release_idle", {busy, in_ready, pix_valid, frame_done}, 4'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_pixel_sequencer.md
Name: frame_pixel_sequencer

Overview:
- Frame-level controller that sequences one image into the single-pixel-per-strobe window filters (binarize and siblings).
- Accepts upstream pixels via valid/ready and re-emits them as paced strobes tagged with row/col.
- After the last real pixel, injects padding rows so the filter's line buffers drain, then pulses frame_done.
- Sits between the pixel source (DMA/file reader) and the filter's gray_valid/gray inputs.

Parameters:
- IMAGE_WIDTH, 320, pixels per row (>=2).
- IMAGE_HEIGHT, 240, rows per frame (>=1).
- PIX_GAP, 2, idle cycles forced after every strobe (0 = back-to-back).
- FLUSH_ROWS, 1, padding rows emitted after the frame (0 = none).
- PAD_VALUE, 0, 8-bit data value driven on pad strobes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a frame when idle.
- abort  in  1  synchronous abort; sampled in any state.
- in_valid  in  1  upstream pixel valid.
- in_data  in  8  upstream pixel.
- in_ready  out  1  sequencer accepts in_data this cycle.
- pix_valid  out  1  one-cycle strobe to filter (drives gray_valid).
- pix_data  out  8  strobe data (drives gray).
- pix_row  out  16  row of the current strobe.
- pix_col  out  16  column of the current strobe.
- pix_is_pad  out  1  current strobe is padding.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at frame end.
- stall_cnt  out  32  upstream starvation count (optional feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; row/col counters 0.
- States: IDLE, FEED, GAP, FLUSH, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> FEED next cycle; row/col counters cleared.
  - start in any other state is ignored.
- FEED:
  - in_ready=1 combinationally.
  - Handshake (in_valid&in_ready) at cycle t: at t+1, pix_valid=1, pix_data=in_data, pix_row/pix_col = current counters, pix_is_pad=0.
  - Column increments and wraps at IMAGE_WIDTH-1 to 0 with row+1.
  - Next state is GAP if PIX_GAP>0, otherwise stays FEED (one pixel per cycle).
  - No handshake: remain in FEED; outputs hold except pix_valid=0.
- GAP:
  - Lasts PIX_GAP cycles beginning with the strobe cycle; in_ready=0.
  - Strobe period is exactly PIX_GAP+1 cycles.
  - Exit to FEED if more real pixels remain.
  - Otherwise exit to FLUSH if pad strobes remain, else DONE.
- Last real pixel is at row IMAGE_HEIGHT-1, col IMAGE_WIDTH-1. Any further in_valid is not accepted (in_ready stays 0).
- FLUSH:
  - Emits FLUSH_ROWS*IMAGE_WIDTH pad strobes with no handshake, each followed by the same PIX_GAP gap.
  - pix_data=PAD_VALUE, pix_is_pad=1.
  - pix_row continues from IMAGE_HEIGHT upward; pix_col wraps as in FEED.
  - First pad strobe comes PIX_GAP+1 cycles after the last real strobe.
- DONE:
  - Entered PIX_GAP+1 cycles after the final strobe.
  - frame_done=1 for exactly one cycle, then IDLE.
  - If FLUSH_ROWS=0, DONE follows the last real strobe's gap directly.
- pix_valid is a registered one-cycle pulse, never high in two consecutive cycles when PIX_GAP>0.
- pix_row/pix_col/pix_data/pix_is_pad hold their last value between strobes.
- abort=1 (any state):
  - Next cycle: IDLE, pix_valid=0, in_ready=0, no frame_done.
  - abort has priority over start and over a simultaneous handshake; that pixel is not consumed.
- Counters are 16-bit unsigned. IMAGE_HEIGHT+FLUSH_ROWS must be <65536; this is checked by a simulation-time assertion.

Optional Feature:
- Macro: SEQ_STALL_CNT_EN.
- Defined:
  - stall_cnt counts cycles in FEED with in_valid=0.
  - Cleared on the cycle start is accepted; holds its value after DONE/abort.
  - Saturates at 32'hFFFFFFFF.
- Undefined: stall_cnt tied to 0; no counter logic.

Test Plan (IMAGE_WIDTH=4, IMAGE_HEIGHT=3, PIX_GAP=2, FLUSH_ROWS=1, PAD_VALUE=0 unless stated):
- Nominal frame: start, in_valid held high, data 10..21.
  - 12 real strobes spaced 3 cycles; (row,col) = (0,0)..(2,3); pix_data 10..21; pix_is_pad=0.
  - Then 4 pad strobes at row 3, col 0..3, data 0, pix_is_pad=1.
  - frame_done 3 cycles after the last pad strobe; busy falls the cycle after.
- Upstream starvation: in_valid low for 5 cycles before pixel 6.
  - Strobe 6 delayed 5 cycles; sequence otherwise identical.
  - With SEQ_STALL_CNT_EN, stall_cnt=5 at frame_done.
- PIX_GAP=0, FLUSH_ROWS=0:
  - 12 strobes on consecutive cycles, in_ready continuously high during FEED.
  - frame_done 1 cycle after the last strobe; no pad strobes.
- Abort mid-frame: abort asserted in the same cycle as the handshake for pixel 5.
  - That pixel is not strobed; IDLE next cycle; no frame_done.
  - A subsequent start restarts at (0,0).
- Start while busy: pulse start during FLUSH.
  - Ignored; frame completes normally with exactly one frame_done.
- Async reset: rst_n low mid-GAP for less than one clock period.
  - All outputs 0 immediately (before the next edge); IDLE after release.
